register_divider: RTL
=====================

# register_divider

Sequential restoring divider that undoes the pipelined multiply-add stage. The multiply-add stage produces DATA_OUT = A*B + C; this block takes such a word and divisor B and recovers quotient A and remainder C, one quotient bit per clock. It sits on the consumer side of the multiply-add datapath, with a start/busy/done handshake toward the controlling logic.

## Interface
- DATA_WIDTH, default params::DATA_WIDTH (8): width of B, A_out, C_out.
- DATA_OUT_WIDTH, default params::DATA_OUT_WIDTH (16): width of DATA_IN; also the iteration count W.

- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears all state and outputs immediately.
- start  input  1  request; sampled only in IDLE.
- DATA_IN  input  DATA_OUT_WIDTH  dividend (the A*B+C word); latched when start is accepted.
- B  input  DATA_WIDTH  divisor; latched when start is accepted.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse: results valid and updated.
- A_out  output  DATA_WIDTH  quotient, saturated to all ones on overflow.
- C_out  output  DATA_WIDTH  remainder (always < B when B != 0).
- overflow  output  1  true quotient exceeded 2^DATA_WIDTH-1.
- div_by_zero  output  1  latched B was zero.

## Operation
- FSM states: IDLE, CALC, FINISH.
- IDLE: if start=1 at an edge: latch DATA_IN into dividend shift register, B into divisor register, clear partial remainder (DATA_WIDTH+1 bits) and quotient (DATA_OUT_WIDTH bits), load iteration counter with W, set busy. If latched B=0 go to FINISH, else CALC. start=0: stay.
- CALC, each edge: rem' = {rem[DATA_WIDTH-1:0], dividend MSB}; shift dividend left; if rem' >= divisor then rem = rem' - divisor, shift 1 into quotient LSB, else rem = rem', shift 0. Decrement counter; after the W-th iteration go to FINISH.
- FINISH, one edge: register outputs, pulse done, drop busy, return to IDLE.
  - B=0: A_out = all ones, C_out = 0, div_by_zero=1, overflow=0.
  - quotient[DATA_OUT_WIDTH-1:DATA_WIDTH] != 0: A_out = all ones, overflow=1, C_out = true remainder.
  - else: A_out = quotient[DATA_WIDTH-1:0], C_out = rem[DATA_WIDTH-1:0], flags 0.
- A_out, C_out, overflow, div_by_zero hold their values until the next FINISH; they are not cleared by a new start.
- start while busy=1: ignored, no queueing; DATA_IN/B changes while busy have no effect.
- Reset (any time, including mid-CALC): FSM to IDLE; busy, done, A_out, C_out, overflow, div_by_zero, counter, working registers all 0. In-flight operation discarded; no done pulse.

## Timing
- Reset values: all outputs 0.
- start accepted at edge t0: busy high after t0.
- B != 0: iterations at edges t1..tW; FINISH at edge t(W+1): done high and results valid for the cycle after t(W+1); busy low after t(W+1). Latency W+2 edges from accept to done-visible cycle (18 for W=16).
- B = 0: FINISH at edge t1; done visible in cycle after t1.
- done is exactly one cycle wide. The cycle in which done is high is an IDLE cycle: start=1 there is accepted at the next edge (back-to-back throughput W+2 cycles).
- Width rule: divisor compared at DATA_WIDTH+1 bits so rem' never overflows; remainder always fits DATA_WIDTH bits.

## Test plan
- DATA_IN=1000, B=13, start 1 cycle -> done 18 cycles later, A_out=76, C_out=12, overflow=0, div_by_zero=0; busy high exactly 17 cycles.
- DATA_IN=65279, B=255 -> A_out=255, C_out=254, no flags (max exact quotient). DATA_IN=65535, B=255 -> A_out=255, C_out=0, overflow=1.
- DATA_IN=500, B=0 -> done 2 cycles after start, A_out=255, C_out=0, div_by_zero=1; next op DATA_IN=6, B=3 clears flag, A_out=2, C_out=0.
- start held high with new DATA_IN/B during busy -> first result unaffected; second op accepted in the done cycle, its done exactly 18 cycles after the first.
- rst_n pulsed low at iteration 8 -> all outputs 0 asynchronously, no done pulse; subsequent DATA_IN=200, B=7 -> A_out=28, C_out=4.
- Random sweep of 1000 (A<256, B in 1..255, C<B): DATA_IN=A*B+C -> A_out=A, C_out=C, flags 0.

Source files
------------

// File: rtl/register_divider.sv
// Sequential restoring divider: recovers quotient A and remainder C from DATA_IN = A*B + C,
// one quotient bit per clock, with start/busy/done handshake.
package params;
  localparam int DATA_WIDTH     = 8;
  localparam int DATA_OUT_WIDTH = 16;
endpackage

module register_divider #(
  parameter int DATA_WIDTH     = params::DATA_WIDTH,
  parameter int DATA_OUT_WIDTH = params::DATA_OUT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATA_OUT_WIDTH-1:0] DATA_IN,
  input  logic [DATA_WIDTH-1:0]     B,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_WIDTH-1:0]     A_out,
  output logic [DATA_WIDTH-1:0]     C_out,
  output logic                      overflow,
  output logic                      div_by_zero
);
  localparam int CW = $clog2(DATA_OUT_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t state, state_nxt;

  logic [DATA_OUT_WIDTH-1:0] dividend, quot;
  logic [DATA_WIDTH-1:0]     divisor, rem, diff;
  logic [DATA_WIDTH:0]       rem_sh;
  logic [CW-1:0]             cnt;
  logic                      ge;

  // rem' is one bit wider than the divisor so the shift-in never overflows;
  // the difference is taken only when rem' >= divisor, so it fits DATA_WIDTH bits.
  assign rem_sh = {rem, dividend[DATA_OUT_WIDTH-1]};
  assign ge     = rem_sh >= {1'b0, divisor};
  assign diff   = rem_sh[DATA_WIDTH-1:0] - divisor;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (B == '0) ? FINISH : CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend    <= '0;
      divisor     <= '0;
      rem         <= '0;
      quot        <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      A_out       <= '0;
      C_out       <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dividend <= DATA_IN;
          divisor  <= B;
          rem      <= '0;
          quot     <= '0;
          cnt      <= CW'(DATA_OUT_WIDTH);
        end
        CALC: begin
          dividend <= dividend << 1;
          rem      <= ge ? diff : rem_sh[DATA_WIDTH-1:0];
          quot     <= {quot[DATA_OUT_WIDTH-2:0], ge};
          cnt      <= cnt - CW'(1);
        end
        FINISH: begin
          done <= 1'b1;
          if (divisor == '0) begin
            A_out       <= '1;
            C_out       <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b1;
          end else if (quot[DATA_OUT_WIDTH-1:DATA_WIDTH] != '0) begin
            A_out       <= '1;
            C_out       <= rem;
            overflow    <= 1'b1;
            div_by_zero <= 1'b0;
          end else begin
            A_out       <= quot[DATA_WIDTH-1:0];
            C_out       <= rem;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
